// File: rtl/seg7_pkg.sv
// Shared types, segment table and BCD helpers for the 7-seg scanner.
// Build option SEG7_LZ_BLANK_EN selects leading-zero blanking in the top.
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  localparam int   BCD_W     = 16;
  localparam int   BCD_MAX   = 9999;
  localparam seg_t SEG_BLANK = 7'h7F;

  // active-low, bit6=g .. bit0=a
  localparam seg_t SEG_LUT [10] = '{
    7'b1000000,
    7'b1111001,
    7'b0100100,
    7'b0110000,
    7'b0011001,
    7'b0010010,
    7'b0000010,
    7'b1111000,
    7'b0000000,
    7'b0010000
  };

  function automatic seg_t seg_encode(
    input bcd_t d
  );
    seg_t s;
    if (d > 4'd9) s = SEG_LUT[0];
    else          s = SEG_LUT[d];
    return s;
  endfunction

  function automatic logic [BCD_W-1:0] bcd_add3(
    input logic [BCD_W-1:0] b
  );
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Valid/ready value port into the 7-seg scan controller.
// Master is the application datapath, slave is seg7_scan_ctrl.
interface seg7_scan_ctrl_if #(
  parameter int DATA_W = 14
);

  logic [DATA_W-1:0] val_in;
  logic              val_valid;
  logic              val_ready;

  modport master (
    output val_in,
    output val_valid,
    input  val_ready
  );

  modport slave (
    input  val_in,
    input  val_valid,
    output val_ready
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle.
// Saturates inputs above 9999 and flags them through sat.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_val,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              load,
  output logic [BCD_W-1:0]  bcd,
  output logic              sat
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] MAX_V =
    DATA_W'(BCD_MAX);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic              ready_q, ready_d;
  logic              load_q, load_d;
  logic              over;

  assign over = in_val > MAX_V;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = over ? MAX_V : in_val;
          sat_d   = over;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, bin_d} =
          {bcd_add3(bcd_q), bin_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W - 1))
          state_d = LOAD;
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = state_d == IDLE;
    load_d  = state_d == LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      ready_q <= 1'b1;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      ready_q <= ready_d;
      load_q  <= load_d;
    end
  end

  assign in_ready = ready_q;
  assign load     = load_q;
  assign bcd      = bcd_q;
  assign sat      = sat_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit 7-seg controller: BCD conversion, display latch, digit scan.
// Define SEG7_LZ_BLANK_EN to blank leading zeros on digits 1..3.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DATA_W      = 14,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_ctrl_if.slave   bus,
  output logic [DIGITS-1:0] an,
  output seg_t              cathode,
  output logic              ovf
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);

  logic [BCD_W-1:0]  conv_bcd;
  logic              conv_load;
  logic              conv_sat;
  logic              conv_ready;

  logic [BCD_W-1:0]  disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  seg_t              cath_q, cath_d;
  logic              last;
  logic              blank;
  bcd_t              digit;

  bin2bcd_seq #(
    .DATA_W (DATA_W)
  ) u_conv (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_val   (bus.val_in),
    .in_valid (bus.val_valid),
    .in_ready (conv_ready),
    .load     (conv_load),
    .bcd      (conv_bcd),
    .sat      (conv_sat)
  );

  assign bus.val_ready = conv_ready;

`ifdef SEG7_LZ_BLANK_EN
  logic [DIGITS-1:0] lz;
  logic              zrun;

  // lz[k] set when digits k..top are all zero
  always_comb begin
    lz   = '0;
    zrun = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zrun  = zrun && (disp_q[4*k +: 4] == 4'd0);
      lz[k] = zrun;
    end
    blank = lz[idx_q];
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    disp_d = conv_load ? conv_bcd : disp_q;
    ovf_d  = conv_load ? conv_sat : ovf_q;

    last  = pre_q == PW'(REFRESH_DIV - 1);
    pre_d = last ? '0 : pre_q + 1'b1;
    idx_d = idx_q;
    if (last)
      idx_d = (idx_q == IW'(DIGITS - 1)) ?
              '0 : idx_q + 1'b1;

    digit  = disp_q[{idx_q, 2'b00} +: 4];
    an_d   = blank ? '1 :
             ~(DIGITS'(1) << idx_q);
    cath_d = blank ? SEG_BLANK :
             seg_encode(digit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
      pre_q  <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      cath_q <= SEG_BLANK;
    end else begin
      disp_q <= disp_d;
      ovf_q  <= ovf_d;
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      cath_q <= cath_d;
    end
  end

  assign an      = an_q;
  assign cathode = cath_q;
  assign ovf     = ovf_q;

endmodule
